// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } rx_state_t;

  localparam logic RX_IDLE_LEVEL = 1'b1;

  function automatic int frame_bits(input int data_bits, input int parity_en,
                                    input int stop_bits);
    return data_bits + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/rx_bit_counter.sv
// Frame bit counter: counts accepted strobes and flags the strobe that
// completes the frame.
module rx_bit_counter #(
  parameter int LIMIT = 9
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       en,
  output logic [3:0] count,
  output logic       last
);

  assign last = en && (count == 4'(LIMIT - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != 4'(LIMIT))) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/rx_frame_sr.sv
// Parametrised UART receive shift register: captures one frame bit by bit
// and checks parity, framing and overrun.
module rx_frame_sr
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic                 shift_strobe,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] packet_data,
  output logic                 parity_bit,
  output logic [STOP_BITS-1:0] stop_bits,
  output logic [3:0]           bit_count,
  output logic                 frame_done,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun_error
);

  localparam int FB = frame_bits(DATA_BITS, PARITY_EN, STOP_BITS);
  localparam logic ODD = (PARITY_ODD != 0);

  rx_state_t       state;
  logic [FB-1:0]   shift_reg;
  logic [FB-1:0]   nxt_reg;
  logic            accept;
  logic            last;
  logic [DATA_BITS-1:0] nxt_data;
  logic [STOP_BITS-1:0] nxt_stop;
  logic            nxt_par;
  logic            nxt_perr;
  logic            nxt_ferr;

  // FULL blocks further shifting; clear wins over a simultaneous strobe.
  assign accept  = shift_strobe && !clear && (state != FULL);
  assign nxt_reg = {serial_in, shift_reg[FB-1:1]};

  rx_bit_counter #(.LIMIT(FB)) u_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .en    (accept),
    .count (bit_count),
    .last  (last)
  );

  assign nxt_data = nxt_reg[DATA_BITS-1:0];
  assign nxt_stop = nxt_reg[FB-1 -: STOP_BITS];
  assign nxt_ferr = ~&nxt_stop;

  generate
    if (PARITY_EN != 0) begin : g_par
      assign nxt_par    = nxt_reg[DATA_BITS];
      assign parity_bit = shift_reg[DATA_BITS];
      assign nxt_perr   = ((^nxt_data) ^ nxt_par) != ODD;
    end else begin : g_nopar
      assign nxt_par    = 1'b1;
      assign parity_bit = 1'b1;
      assign nxt_perr   = 1'b0;
    end
  endgenerate

  assign stop_bits = shift_reg[FB-1 -: STOP_BITS];

  always_comb begin
    packet_data = shift_reg[DATA_BITS-1:0];
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < DATA_BITS; i++) begin
        packet_data[i] = shift_reg[DATA_BITS-1-i];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      shift_reg     <= {FB{RX_IDLE_LEVEL}};
      frame_done    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else if (clear) begin
      state         <= IDLE;
      shift_reg     <= {FB{RX_IDLE_LEVEL}};
      frame_done    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      frame_done <= accept && last;
      if (accept) begin
        shift_reg <= nxt_reg;
        state     <= last ? FULL : SHIFT;
        if (last) begin
          parity_error  <= nxt_perr;
          framing_error <= nxt_ferr;
        end
      end
      if (shift_strobe && (state == FULL)) begin
        overrun_error <= 1'b1;
      end
    end
  end

endmodule

// File: doc/rx_frame_sr.md
Name: rx_frame_sr

Overview:
Parametrised successor to the fixed 9-bit UART receive shift register. Captures one serial frame (data, optional parity, one or two stop bits) bit by bit on shift_strobe. Counts received bits, flags frame completion, and checks parity, framing and overrun. Sits between the receive timer/FSM, which generates shift_strobe at mid-bit, and the RX data buffer.

Parameters:
DATA_BITS, 8, data field width; legal range 5..9.
PARITY_EN, 0, 1 = frame carries a parity bit after the data field.
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; 1 or 2.
MSB_FIRST, 0, 1 = first received data bit is the data MSB.

Ports:
clk  in  1  system clock, rising edge.
n_rst  in  1  asynchronous active-low reset.
clear  in  1  synchronous; discard the current frame and rearm.
shift_strobe  in  1  sample serial_in this cycle.
serial_in  in  1  receive line.
packet_data  out  DATA_BITS  data field, in natural bit order.
parity_bit  out  1  received parity bit; constant 1 when PARITY_EN=0.
stop_bits  out  STOP_BITS  received stop bits.
bit_count  out  4  bits received in the current frame.
frame_done  out  1  single-cycle pulse when the frame is complete.
parity_error  out  1  registered at completion; held until clear or the next completion.
framing_error  out  1  registered at completion; any stop bit 0.
overrun_error  out  1  sticky; a strobe arrived while the frame was FULL.

Behaviour:
- FRAME_BITS = DATA_BITS + PARITY_EN + STOP_BITS.
- The internal register is FRAME_BITS wide.
- Each accepted strobe shifts the register right, with serial_in entering the MSB. After a full frame, stop bits occupy the MSBs and the first bit received sits in bit 0.
- Reset (async) and clear (sync) give identical results:
  - register all ones, so packet_data = all ones, parity_bit = 1, stop_bits = all ones;
  - bit_count = 0, state IDLE;
  - frame_done, parity_error, framing_error, overrun_error = 0.
- clear has priority over shift_strobe in the same cycle. The strobe is dropped.
- States:
  - IDLE (count 0) -> SHIFT on the first strobe.
  - SHIFT -> FULL on the strobe that makes count = FRAME_BITS.
  - FULL -> IDLE only via clear or reset.
- In IDLE and SHIFT, a strobe shifts the register and increments bit_count. With no strobe, everything holds; gaps of any length are legal.
- Completion edge (the strobe taking count to FRAME_BITS):
  - the register and all error flags update at that edge, computed from the post-shift contents;
  - frame_done is high for exactly the following cycle.
- parity_error = (XOR of data bits ^ parity_bit) != PARITY_ODD. Tied 0 when PARITY_EN=0.
- framing_error = any received stop bit equals 0.
- In FULL, a strobe does not shift the register or change bit_count, and sets overrun_error. overrun_error stays set until clear or reset. frame_done does not re-pulse.
- packet_data is combinational from the register at all times, not only at completion. When MSB_FIRST=1, the data field is bit-reversed onto packet_data.
- Reset mid-frame: all state returns to reset values immediately, with no partial frame retained.
- bit_count never exceeds FRAME_BITS; the maximum is 12.

Decomposition:
- Package uart_rx_pkg holds:
  - the rx_state_t enum (IDLE, SHIFT, FULL);
  - a function frame_bits(DATA_BITS, PARITY_EN, STOP_BITS);
  - the constant RX_IDLE_LEVEL = 1'b1.
- One sub-module, rx_bit_counter: 4-bit counter with sync clear, enable, and a terminal-count compare against a parameterised limit. It drives bit_count and the SHIFT->FULL decision.
- Parity and stop-bit checks stay inline.

Test Plan:
1. Defaults; send 0x4A LSB-first (0,1,0,1,0,0,1,0), then stop bit 1.
   -> After the 9th strobe: packet_data = 0x4A, stop_bits = 1, bit_count = 9, one-cycle frame_done, both errors 0.
2. Same data, stop bit 0.
   -> framing_error = 1 at completion; a following clear drops it to 0 and restores packet_data = 0xFF.
3. PARITY_EN=1, even parity; data 0x07, parity bit 1, stop 1.
   -> parity_error = 0.
   Repeat with parity bit 0.
   -> parity_error = 1.
   PARITY_ODD=1 with parity bit 0.
   -> parity_error = 0.
4. Defaults; strobes with gaps of 0, 1 and 3 idle cycles between bits.
   -> Identical result to case 1.
   Then 2 extra strobes with serial_in = 0 in FULL.
   -> overrun_error = 1, packet_data still 0x4A, no second frame_done.
5. Reset mid-frame: n_rst low after 4 strobes.
   -> All outputs return to reset values immediately.
   clear asserted together with a strobe.
   -> bit_count = 0, strobe ignored.
6. DATA_BITS=7, STOP_BITS=2, MSB_FIRST=1; send 1,0,0,0,0,0,1, then 1,1.
   -> packet_data = 7'h41, stop_bits = 2'b11, frame_done after the 9th strobe.
